// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Brief    : Write-back, write-allocate set-associative data cache controller.
//            Owns tag/valid/dirty/data arrays, serves single-word CPU requests,
//            refills/evicts whole lines over a burst memory handshake and
//            drives the companion LRU unit.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
  parameter int way_bits    = 2,
  parameter int index_width = 12,
  parameter int tag_width   = 16,
  parameter int offset_bits = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  // CPU request / response
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic                                     req_we_i,
  input  logic [tag_width+index_width+offset_bits-1:0] req_addr_i,
  input  logic [31:0]                              req_wdata_i,
  output logic                                     resp_valid_o,
  output logic [31:0]                              resp_rdata_o,
  // LRU unit
  output logic [index_width-1:0]                   lru_index_o,
  output logic                                     lru_write_en_o,
  output logic [way_bits-1:0]                      lru_set_num_o,
  input  logic [way_bits-1:0]                      lru_set_i,
  // Memory burst interface
  output logic                                     mem_req_valid_o,
  input  logic                                     mem_req_ready_i,
  output logic                                     mem_we_o,
  output logic [tag_width+index_width-1:0]         mem_addr_o,
  output logic [31:0]                              mem_wdata_o,
  input  logic                                     mem_rdata_valid_i,
  input  logic [31:0]                              mem_rdata_i
);

  localparam int C_WAYS  = 2 ** way_bits;
  localparam int C_DEPTH = 2 ** index_width;
  localparam int C_WORDS = 2 ** offset_bits;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_VICTIM  = 3'd2,
    ST_WB_REQ  = 3'd3,
    ST_WB_DATA = 3'd4,
    ST_RF_REQ  = 3'd5,
    ST_RF_DATA = 3'd6,
    ST_ACCESS  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched request and per-miss bookkeeping
  logic                   r_we;
  logic [tag_width-1:0]   r_tag;
  logic [index_width-1:0] r_index;
  logic [offset_bits-1:0] r_offset;
  logic [31:0]            r_wdata;
  logic [way_bits-1:0]    r_way;      // hit way or chosen victim way
  logic [tag_width-1:0]   r_vtag;     // tag of the line being evicted
  logic [offset_bits-1:0] r_beat;     // burst word counter, wraps per burst

  // Cache storage; only valid/dirty are reset
  logic [C_DEPTH-1:0][C_WAYS-1:0] r_valid;
  logic [C_DEPTH-1:0][C_WAYS-1:0] r_dirty;
  logic [tag_width-1:0]           r_tags [C_WAYS][C_DEPTH];
  logic [31:0]                    r_data [C_WAYS][C_DEPTH][C_WORDS];

  logic                w_hit;
  logic [way_bits-1:0] w_hit_way;
  logic                w_any_inv;
  logic [way_bits-1:0] w_inv_way;
  logic [way_bits-1:0] w_victim;
  logic                w_victim_dirty;
  logic                w_last_beat;
  logic                w_beat_wr;
  logic                w_fill_done;
  logic                w_acc_wr;

  // Tag compare and victim selection at the latched index
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_any_inv = 1'b0;
    w_inv_way = '0;
    // Descending scan so the lowest-numbered matching way wins
    for (int w = C_WAYS - 1; w >= 0; w--) begin
      if (r_valid[r_index][way_bits'(w)] && (r_tags[w][r_index] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = way_bits'(w);
      end
      if (!r_valid[r_index][way_bits'(w)]) begin
        w_any_inv = 1'b1;
        w_inv_way = way_bits'(w);
      end
    end
    w_victim       = w_any_inv ? w_inv_way : lru_set_i;
    w_victim_dirty = r_valid[r_index][w_victim] & r_dirty[r_index][w_victim];
  end

  assign w_last_beat = (r_beat == offset_bits'(C_WORDS - 1));
  assign w_beat_wr   = (r_state == ST_RF_DATA) && mem_rdata_valid_i && !rst_i;
  assign w_fill_done = w_beat_wr && w_last_beat;
  assign w_acc_wr    = (r_state == ST_ACCESS) && r_we && !rst_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (req_valid_i)     w_next = ST_LOOKUP;
      ST_LOOKUP:  w_next = w_hit ? ST_ACCESS : ST_VICTIM;
      ST_VICTIM:  w_next = w_victim_dirty ? ST_WB_REQ : ST_RF_REQ;
      ST_WB_REQ:  if (mem_req_ready_i) w_next = ST_WB_DATA;
      ST_WB_DATA: if (w_last_beat)     w_next = ST_RF_REQ;
      ST_RF_REQ:  if (mem_req_ready_i) w_next = ST_RF_DATA;
      ST_RF_DATA: if (w_fill_done)     w_next = ST_ACCESS;
      ST_ACCESS:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Request latch, way selection and burst counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we     <= 1'b0;
      r_tag    <= '0;
      r_index  <= '0;
      r_offset <= '0;
      r_wdata  <= '0;
      r_way    <= '0;
      r_vtag   <= '0;
      r_beat   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_we                       <= req_we_i;
            {r_tag, r_index, r_offset} <= req_addr_i;
            r_wdata                    <= req_wdata_i;
          end
        end
        ST_LOOKUP:  if (w_hit) r_way <= w_hit_way;
        ST_VICTIM: begin
          r_way  <= w_victim;
          r_vtag <= r_tags[w_victim][r_index];
        end
        ST_WB_DATA: r_beat <= r_beat + 1'b1;
        ST_RF_DATA: if (mem_rdata_valid_i) r_beat <= r_beat + 1'b1;
        default: ;
      endcase
    end
  end

  // Valid/dirty bits: cleared on reset, set by refill completion and writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_fill_done) begin
        r_valid[r_index][r_way] <= 1'b1;
        r_dirty[r_index][r_way] <= 1'b0;
      end
      if (w_acc_wr) r_dirty[r_index][r_way] <= 1'b1;
    end
  end

  // Tag array update at refill completion
  always_ff @(posedge clk_i) begin
    if (w_fill_done) r_tags[r_way][r_index] <= r_tag;
  end

  // Data array: refill beats and CPU write hits
  always_ff @(posedge clk_i) begin
    if (w_beat_wr) r_data[r_way][r_index][r_beat]   <= mem_rdata_i;
    if (w_acc_wr)  r_data[r_way][r_index][r_offset] <= r_wdata;
  end

  assign lru_index_o   = r_index;
  assign lru_set_num_o = r_way;

  // Output decode; everything forced quiet while reset is asserted
  always_comb begin
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    resp_rdata_o    = '0;
    lru_write_en_o  = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    if (!rst_i) begin
      case (r_state)
        ST_IDLE: req_ready_o = 1'b1;
        ST_WB_REQ: begin
          mem_req_valid_o = 1'b1;
          mem_we_o        = 1'b1;
          mem_addr_o      = {r_vtag, r_index};
        end
        ST_WB_DATA: begin
          mem_we_o    = 1'b1;
          mem_wdata_o = r_data[r_way][r_index][r_beat];
        end
        ST_RF_REQ: begin
          mem_req_valid_o = 1'b1;
          mem_addr_o      = {r_tag, r_index};
        end
        ST_ACCESS: begin
          resp_valid_o   = 1'b1;
          lru_write_en_o = 1'b1;
          if (!r_we) resp_rdata_o = r_data[r_way][r_index][r_offset];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
